// File: rtl/known_sink_update_pkg.sv
// Shared definitions for the known-sinks learning stage: word width, address map,
// table capacity, FSM state encodings and the entry address helper.
package known_sink_update_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 11;
    localparam int MAX_SINKS_DEF = 32;

    localparam logic [ADDR_WIDTH-1:0] FLAG_ADDR_DEF          = 11'h002;
    localparam logic [ADDR_WIDTH-1:0] SINK_BASE_DEF          = 11'h008;
    localparam logic [ADDR_WIDTH-1:0] NBR_TABLE_BASE_DEF     = 11'h048;
    localparam logic [ADDR_WIDTH-1:0] CLUSTER_TABLE_BASE_DEF = 11'h248;
    localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR_DEF         = 11'h688;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RDCNT = 3'd2,
        ST_SCAN  = 3'd3,
        ST_WRENT = 3'd4,
        ST_WRCNT = 3'd5,
        ST_WRFLG = 3'd6
    } state_t;

    // Entries are 16-bit words, so index j sits at base + 2*j.
    function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [ADDR_WIDTH-1:0] base,
                                                         input logic [WORD_WIDTH-1:0] idx);
        logic [WORD_WIDTH-1:0] off;
        off = idx << 1;
        return base + off[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/known_sink_update_scan.sv
// sink_scan_counter: table index j, address of the next entry to read, and the
// "next index reaches the count" terminal compare used by the scan loop.
module sink_scan_counter
    import known_sink_update_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] SINK_BASE = SINK_BASE_DEF
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  i_clr,
    input  logic                  i_inc,
    input  logic [WORD_WIDTH-1:0] i_n,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_last
);

    logic [WORD_WIDTH-1:0] r_j;
    logic [WORD_WIDTH-1:0] w_j_next;

    assign w_j_next    = r_j + 16'd1;
    assign o_next_addr = entry_addr(SINK_BASE, w_j_next);
    assign o_last      = (w_j_next == i_n);

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_j <= '0;
        end else if (i_clr) begin
            r_j <= '0;
        end else if (i_inc) begin
            r_j <= w_j_next;
        end
    end

endmodule

// File: rtl/known_sink_update.sv
// Known-sinks table updater: scans for an announced sink ID and appends it if absent.
// Optional KNOWN_SINK_FLAG_CLEAR_EN adds a final write zeroing the forAggregation flag word.
module known_sink_update
    import known_sink_update_pkg::*;
#(
    parameter int                    MAX_SINKS  = MAX_SINKS_DEF,
    parameter logic [ADDR_WIDTH-1:0] SINK_BASE  = SINK_BASE_DEF,
    parameter logic [ADDR_WIDTH-1:0] COUNT_ADDR = COUNT_ADDR_DEF,
    parameter logic [ADDR_WIDTH-1:0] FLAG_ADDR  = FLAG_ADDR_DEF
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] SINK_ID,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  added,
    output logic                  duplicate,
    output logic                  full,
    output logic                  done
);

    localparam logic [WORD_WIDTH-1:0] MAX_W = WORD_WIDTH'(MAX_SINKS);

`ifndef KNOWN_SINK_FLAG_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] unused_flag_addr = FLAG_ADDR;
`endif

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_next;
    logic                  r_wr,    w_wr_next;
    logic [WORD_WIDTH-1:0] r_dout,  w_dout_next;
    logic [WORD_WIDTH-1:0] r_id,    w_id_next;
    logic [WORD_WIDTH-1:0] r_n,     w_n_next;
    logic                  r_added, w_added_next;
    logic                  r_dup,   w_dup_next;
    logic                  r_full,  w_full_next;
    logic                  r_done,  w_done_next;

    logic                  w_cnt_clr;
    logic                  w_cnt_inc;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_last;
    logic [WORD_WIDTH-1:0] w_count;

    // A corrupted count larger than the table is treated as a full table.
    assign w_count = (data_in > MAX_W) ? MAX_W : data_in;

    sink_scan_counter #(
        .SINK_BASE (SINK_BASE)
    ) u_scan (
        .clock       (clock),
        .nrst        (nrst),
        .i_clr       (w_cnt_clr),
        .i_inc       (w_cnt_inc),
        .i_n         (r_n),
        .o_next_addr (w_next_addr),
        .o_last      (w_last)
    );

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_addr  <= COUNT_ADDR;
            r_wr    <= 1'b0;
            r_dout  <= '0;
            r_id    <= '0;
            r_n     <= '0;
            r_added <= 1'b0;
            r_dup   <= 1'b0;
            r_full  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_wr    <= w_wr_next;
            r_dout  <= w_dout_next;
            r_id    <= w_id_next;
            r_n     <= w_n_next;
            r_added <= w_added_next;
            r_dup   <= w_dup_next;
            r_full  <= w_full_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_wr_next    = 1'b0;
        w_dout_next  = r_dout;
        w_id_next    = r_id;
        w_n_next     = r_n;
        w_added_next = r_added;
        w_dup_next   = r_dup;
        w_full_next  = r_full;
        w_done_next  = r_done;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_added_next = 1'b0;
                    w_dup_next   = 1'b0;
                    w_full_next  = 1'b0;
                    w_done_next  = 1'b0;
                    w_addr_next  = COUNT_ADDR;
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (start) begin
                    w_id_next    = SINK_ID;
                    w_state_next = ST_RDCNT;
                end
            end
            ST_RDCNT: begin
                w_n_next  = w_count;
                w_cnt_clr = 1'b1;
                if (w_count == '0) begin
                    w_wr_next    = 1'b1;
                    w_addr_next  = SINK_BASE;
                    w_dout_next  = r_id;
                    w_state_next = ST_WRENT;
                end else begin
                    w_addr_next  = SINK_BASE;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (data_in == r_id) begin
                    w_dup_next   = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_inc   = 1'b1;
                    w_addr_next = w_next_addr;
                    if (w_last) begin
                        if (r_n == MAX_W) begin
                            w_full_next  = 1'b1;
                            w_done_next  = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_wr_next    = 1'b1;
                            w_dout_next  = r_id;
                            w_state_next = ST_WRENT;
                        end
                    end
                end
            end
            // Entry is committed this edge; the count follows so a reset in between
            // leaves the new entry outside the valid range.
            ST_WRENT: begin
                w_wr_next    = 1'b1;
                w_addr_next  = COUNT_ADDR;
                w_dout_next  = r_n + 16'd1;
                w_state_next = ST_WRCNT;
            end
            ST_WRCNT: begin
`ifdef KNOWN_SINK_FLAG_CLEAR_EN
                w_wr_next    = 1'b1;
                w_addr_next  = FLAG_ADDR;
                w_dout_next  = '0;
                w_state_next = ST_WRFLG;
`else
                w_added_next = 1'b1;
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
`endif
            end
            ST_WRFLG: begin
                w_added_next = 1'b1;
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign address   = r_addr;
    assign wr_en     = r_wr;
    assign data_out  = r_dout;
    assign added     = r_added;
    assign duplicate = r_dup;
    assign full      = r_full;
    assign done      = r_done;

endmodule

// File: tb/tb_known_sink_update.sv
// Directed bench for known_sink_update with a word-addressed memory model.
module tb_known_sink_update;

    logic        clock = 1'b0;
    logic        nrst  = 1'b0;
    logic        en    = 1'b0;
    logic        start = 1'b0;
    logic [15:0] SINK_ID = 16'h0;
    logic [15:0] data_in;
    logic [10:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic        added, duplicate, full, done;

    logic [15:0] mem [0:1023];
    logic        pk_en = 1'b0;
    logic [10:0] pk_a  = 11'h0;
    logic [15:0] pk_d  = 16'h0;
    int          wr_total = 0;
    int          checks = 0;
    int          errors = 0;

`ifdef KNOWN_SINK_FLAG_CLEAR_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    localparam logic [10:0] A_FLAG  = 11'h002;
    localparam logic [10:0] A_E0    = 11'h008;
    localparam logic [10:0] A_E2    = 11'h00C;
    localparam logic [10:0] A_COUNT = 11'h688;

    known_sink_update dut (
        .clock     (clock),
        .nrst      (nrst),
        .en        (en),
        .start     (start),
        .SINK_ID   (SINK_ID),
        .data_in   (data_in),
        .address   (address),
        .wr_en     (wr_en),
        .data_out  (data_out),
        .added     (added),
        .duplicate (duplicate),
        .full      (full),
        .done      (done)
    );

    always #5 clock = ~clock;

    assign data_in = mem[address[10:1]];

    always @(posedge clock) begin
        if (pk_en) mem[pk_a[10:1]] <= pk_d;
        else if (wr_en) mem[address[10:1]] <= data_out;
        if (wr_en) wr_total <= wr_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [10:0] a, input logic [15:0] d);
        pk_en = 1'b1; pk_a = a; pk_d = d;
        @(posedge clock); #1;
        pk_en = 1'b0;
    endtask

    task automatic arm();
        en = 1'b1;
        @(posedge clock); #1;
        en = 1'b0;
    endtask

    task automatic run_start(input logic [15:0] id, output int edge_n, output int wrs);
        int w0;
        w0 = wr_total;
        SINK_ID = id; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        edge_n = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clock); #1;
            if (done) begin
                edge_n = e;
                break;
            end
        end
        wrs = wr_total - w0;
    endtask

    int ed, nw;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'hFFFF;

        // reset values
        #12;
        check("rst_addr", 32'(address), 32'(A_COUNT));
        check("rst_wr", 32'(wr_en), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_flags", {28'd0, added, duplicate, full, done}, 32'd0);
        nrst = 1'b1;
        @(posedge clock); #1;

        // append to empty table
        poke(A_COUNT, 16'd0);
        poke(A_FLAG, 16'hBEEF);
        arm();
        check("arm_addr", 32'(address), 32'(A_COUNT));
        run_start(16'h0005, ed, nw);
        check("a_edge", 32'(ed), 32'(3 + EXTRA));
        check("a_flags", {28'd0, added, duplicate, full, done}, 32'b1001);
        check("a_entry", 32'(mem[A_E0[10:1]]), 32'h5);
        check("a_count", 32'(mem[A_COUNT[10:1]]), 32'h1);
        check("a_wrs", 32'(nw), 32'(2 + EXTRA));
        check("a_flagword", 32'(mem[A_FLAG[10:1]]), EXTRA ? 32'h0 : 32'hBEEF);

        // duplicate at index 1
        poke(A_COUNT, 16'd3);
        poke(11'h008, 16'd7);
        poke(11'h00A, 16'd9);
        poke(11'h00C, 16'd5);
        poke(A_FLAG, 16'hBEEF);
        arm();
        check("b_cleared", {28'd0, added, duplicate, full, done}, 32'd0);
        run_start(16'h0009, ed, nw);
        check("b_edge", 32'(ed), 32'd3);
        check("b_flags", {28'd0, added, duplicate, full, done}, 32'b0101);
        check("b_wrs", 32'(nw), 32'd0);
        check("b_count", 32'(mem[A_COUNT[10:1]]), 32'd3);

        // full table, no match
        poke(A_COUNT, 16'd32);
        for (int i = 0; i < 32; i++) poke(11'h008 + 11'(2 * i), 16'h0100 + 16'(i));
        arm();
        run_start(16'h00AA, ed, nw);
        check("c_edge", 32'(ed), 32'd33);
        check("c_flags", {28'd0, added, duplicate, full, done}, 32'b0011);
        check("c_wrs", 32'(nw), 32'd0);

        // stored count above capacity clamps to full
        poke(A_COUNT, 16'd40);
        arm();
        run_start(16'h00AA, ed, nw);
        check("clamp_edge", 32'(ed), 32'd33);
        check("clamp_flags", {28'd0, added, duplicate, full, done}, 32'b0011);
        check("clamp_wrs", 32'(nw), 32'd0);

        // duplicate at last index of a full table
        poke(A_COUNT, 16'd32);
        arm();
        run_start(16'h011F, ed, nw);
        check("dup31_edge", 32'(ed), 32'd33);
        check("dup31_flags", {28'd0, added, duplicate, full, done}, 32'b0101);

        // append with count 2
        poke(A_COUNT, 16'd2);
        poke(11'h008, 16'd1);
        poke(11'h00A, 16'd2);
        poke(A_FLAG, 16'hBEEF);
        arm();
        run_start(16'h0004, ed, nw);
        check("d_edge", 32'(ed), 32'(5 + EXTRA));
        check("d_flags", {28'd0, added, duplicate, full, done}, 32'b1001);
        check("d_entry", 32'(mem[A_E2[10:1]]), 32'h4);
        check("d_count", 32'(mem[A_COUNT[10:1]]), 32'h3);
        check("d_wrs", 32'(nw), 32'(2 + EXTRA));
        check("d_flagword", 32'(mem[A_FLAG[10:1]]), EXTRA ? 32'h0 : 32'hBEEF);

        // reset between entry write and count write
        poke(A_COUNT, 16'd2);
        poke(A_E2, 16'h0000);
        arm();
        SINK_ID = 16'h0006; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("r_entry_written", 32'(mem[A_E2[10:1]]), 32'h6);
        check("r_wr_before", 32'(wr_en), 32'd1);
        nrst = 1'b0;
        #1;
        check("r_wr_after", 32'(wr_en), 32'd0);
        check("r_addr_after", 32'(address), 32'(A_COUNT));
        repeat (2) @(posedge clock);
        #1 nrst = 1'b1;
        check("r_count_kept", 32'(mem[A_COUNT[10:1]]), 32'd2);
        check("r_done", 32'(done), 32'd0);

        // start in IDLE without en is ignored
        nw = wr_total;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("idle_start_wrs", 32'(wr_total - nw), 32'd0);
        check("idle_start_done", 32'(done), 32'd0);

        // en and start together: only en acts, a later start runs from ARMED
        poke(A_COUNT, 16'd0);
        en = 1'b1; start = 1'b1; SINK_ID = 16'h0077;
        @(posedge clock); #1;
        en = 1'b0; start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("en_start_done", 32'(done), 32'd0);
        check("en_start_count", 32'(mem[A_COUNT[10:1]]), 32'd0);
        run_start(16'h0077, ed, nw);
        check("e_edge", 32'(ed), 32'(3 + EXTRA));
        check("e_entry", 32'(mem[A_E0[10:1]]), 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
